// File: rtl/lwc_pkg.sv
// Shared defaults, FSM state type and bank-index helpers for line_window_ctrl.
package lwc_pkg;

    localparam int unsigned LWC_PIX_W   = 8;
    localparam int unsigned LWC_LINE_W  = 384;
    localparam int unsigned LWC_N_LINES = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } lwc_state_e;

    // Width of a bank index for N_LINES+1 banks (at least one bit).
    function automatic int unsigned lwc_bank_w(input int unsigned n_lines);
        return (n_lines + 1 > 2) ? $clog2(n_lines + 1) : 1;
    endfunction

    // (v + 1) mod m without a divider.
    function automatic int unsigned lwc_mod_inc(input int unsigned v, input int unsigned m);
        return (v + 1 >= m) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/lwc_line_ram.sv
// One line buffer: single write port, single registered read port, contents not reset.
module lwc_line_ram #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 384,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage write and registered read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_window_ctrl.sv
// Camera line buffer: stores N_LINES+1 rotating lines and emits a vertical
// window column per accepted pixel.
// Optional: LWC_BORDER_REPLICATE_EN -- window valid from the first completed
// line, missing older slices replicate the oldest stored line.
module line_window_ctrl
    import lwc_pkg::*;
#(
    parameter int unsigned PIX_W   = LWC_PIX_W,
    parameter int unsigned LINE_W  = LWC_LINE_W,
    parameter int unsigned N_LINES = LWC_N_LINES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PCLK,
    input  logic                       Href,
    input  logic                       VSYNC,
    input  logic [PIX_W-1:0]           in_pixel,
    output logic [N_LINES*PIX_W-1:0]   win_col,
    output logic                       win_valid,
    output logic [$clog2(LINE_W)-1:0]  win_x,
    output logic                       frame_start,
    output logic                       line_end,
    output logic                       ovf
);

    localparam int unsigned AW = $clog2(LINE_W);
    localparam int unsigned CW = $clog2(LINE_W + 1);
    localparam int unsigned NB = N_LINES + 1;
    localparam int unsigned BW = lwc_bank_w(N_LINES);
    localparam int unsigned SW = PIX_W + 3;
    localparam int unsigned WW = N_LINES * PIX_W;

    logic [SW-1:0]    sync1_q, sync2_q;
    logic             pclk_s, href_s, vsync_s;
    logic [PIX_W-1:0] pix_s;
    logic             pclk_prev_q, href_prev_q, vsync_prev_q;
    logic             pclk_rise_q, pclk_rise_d;
    logic [PIX_W-1:0] pix_q;
    lwc_state_e       state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [BW-1:0]    wr_bank_q, wr_bank_d;
    logic [BW-1:0]    lines_q, lines_d;
    logic             ovf_q, ovf_d;
    logic             rd_vld_q, rd_vld_d;
    logic [AW-1:0]    rd_x_q, rd_x_d;
    logic [BW-1:0]    rd_bank_q, rd_bank_d;
`ifdef LWC_BORDER_REPLICATE_EN
    logic [BW-1:0]    rd_lines_q, rd_lines_d;
`endif
    logic [WW-1:0]    win_col_q, win_col_d;
    logic             win_valid_q, win_valid_d;
    logic [AW-1:0]    win_x_q, win_x_d;
    logic             frame_start_q, frame_start_d;
    logic             line_end_q, line_end_d;
    logic             accept, href_fall, vsync_fall, win_ready, wr_en;
    logic [AW-1:0]    addr;
    logic [PIX_W-1:0] rd_data [NB];

    assign pix_s      = sync2_q[PIX_W-1:0];
    assign pclk_s     = sync2_q[PIX_W];
    assign href_s     = sync2_q[PIX_W+1];
    assign vsync_s    = sync2_q[PIX_W+2];
    assign href_fall  = href_prev_q & ~href_s;
    assign vsync_fall = vsync_prev_q & ~vsync_s;
    assign accept     = (state_q == FRAME) && pclk_rise_q && href_s;
    assign addr       = AW'(col_q);

`ifdef LWC_BORDER_REPLICATE_EN
    assign win_ready = (lines_q != '0);
`else
    assign win_ready = (lines_q == BW'(N_LINES));
`endif

    // Frame FSM, column/bank counters and read issue.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        wr_bank_d     = wr_bank_q;
        lines_d       = lines_q;
        ovf_d         = ovf_q;
        frame_start_d = 1'b0;
        line_end_d    = 1'b0;
        rd_vld_d      = 1'b0;
        rd_x_d        = rd_x_q;
        rd_bank_d     = rd_bank_q;
`ifdef LWC_BORDER_REPLICATE_EN
        rd_lines_d    = rd_lines_q;
`endif
        wr_en         = 1'b0;
        pclk_rise_d   = pclk_s & ~pclk_prev_q;

        case (state_q)
            IDLE: begin
                if (vsync_fall) begin
                    state_d       = FRAME;
                    frame_start_d = 1'b1;
                end
            end
            FRAME: begin
                if (vsync_s) begin
                    state_d = IDLE;
                end else if (accept) begin
                    if (col_q == CW'(LINE_W)) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        col_d     = col_q + CW'(1);
                        rd_vld_d  = win_ready;
                        rd_x_d    = addr;
                        rd_bank_d = wr_bank_q;
`ifdef LWC_BORDER_REPLICATE_EN
                        rd_lines_d = lines_q;
`endif
                    end
                end else if (href_fall) begin
                    col_d      = '0;
                    wr_bank_d  = BW'(lwc_mod_inc(32'(wr_bank_q), NB));
                    lines_d    = (lines_q == BW'(N_LINES)) ? lines_q : lines_q + BW'(1);
                    line_end_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            col_d     = '0;
            wr_bank_d = '0;
            lines_d   = '0;
            ovf_d     = 1'b0;
        end
    end

    // Window column assembly: slice k comes from the bank written k+1 lines ago.
    always_comb begin
        int unsigned kk;
        int unsigned bank;
        kk          = 0;
        bank        = 0;
        win_col_d   = win_col_q;
        win_x_d     = win_x_q;
        win_valid_d = rd_vld_q;
        if (rd_vld_q) begin
            win_x_d = rd_x_q;
            for (int unsigned k = 0; k < N_LINES; k++) begin
`ifdef LWC_BORDER_REPLICATE_EN
                kk = (k >= 32'(rd_lines_q)) ? 32'(rd_lines_q) - 1 : k;
`else
                kk = k;
`endif
                bank = (32'(rd_bank_q) + NB - 1 - kk) % NB;
                win_col_d[k*PIX_W +: PIX_W] = rd_data[BW'(bank)];
            end
        end
    end

    // State, synchronisers and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            pclk_prev_q   <= 1'b0;
            href_prev_q   <= 1'b0;
            vsync_prev_q  <= 1'b0;
            pclk_rise_q   <= 1'b0;
            pix_q         <= '0;
            state_q       <= IDLE;
            col_q         <= '0;
            wr_bank_q     <= '0;
            lines_q       <= '0;
            ovf_q         <= 1'b0;
            rd_vld_q      <= 1'b0;
            rd_x_q        <= '0;
            rd_bank_q     <= '0;
`ifdef LWC_BORDER_REPLICATE_EN
            rd_lines_q    <= '0;
`endif
            win_col_q     <= '0;
            win_valid_q   <= 1'b0;
            win_x_q       <= '0;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
        end else begin
            sync1_q       <= {VSYNC, Href, PCLK, in_pixel};
            sync2_q       <= sync1_q;
            pclk_prev_q   <= pclk_s;
            href_prev_q   <= href_s;
            vsync_prev_q  <= vsync_s;
            pclk_rise_q   <= pclk_rise_d;
            pix_q         <= pix_s;
            state_q       <= state_d;
            col_q         <= col_d;
            wr_bank_q     <= wr_bank_d;
            lines_q       <= lines_d;
            ovf_q         <= ovf_d;
            rd_vld_q      <= rd_vld_d;
            rd_x_q        <= rd_x_d;
            rd_bank_q     <= rd_bank_d;
`ifdef LWC_BORDER_REPLICATE_EN
            rd_lines_q    <= rd_lines_d;
`endif
            win_col_q     <= win_col_d;
            win_valid_q   <= win_valid_d;
            win_x_q       <= win_x_d;
            frame_start_q <= frame_start_d;
            line_end_q    <= line_end_d;
        end
    end

    // Line banks: the bank being written is the only one not read.
    for (genvar b = 0; b < NB; b++) begin : g_bank
        lwc_line_ram #(
            .DW    (PIX_W),
            .DEPTH (LINE_W),
            .AW    (AW)
        ) u_ram (
            .clk   (clk),
            .we    (wr_en && (wr_bank_q == BW'(b))),
            .waddr (addr),
            .wdata (pix_q),
            .re    (wr_en && (wr_bank_q != BW'(b))),
            .raddr (addr),
            .rdata (rd_data[b])
        );
    end

    assign win_col     = win_col_q;
    assign win_valid   = win_valid_q;
    assign win_x       = win_x_q;
    assign frame_start = frame_start_q;
    assign line_end    = line_end_q;
    assign ovf         = ovf_q;

endmodule
